// File: rtl/psec6_spi_core.sv
// psec6_spi_core: SPI slave register file, instruction decoder and sampling clk_enable control (optional PLL gating: PSEC6_SPI_PLL_GATE_EN).
// Latency: writes and instruction strobes land on the 16th frame edge; read data drives poci_spi from the 8th edge.
// Backpressure: none, the host owns spi_clk and every frame is accepted; trigger_in clears clk_enable asynchronously.
module psec6_spi_core (
    input  logic       spi_clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       pico,
    input  logic       trigger_in,
    input  logic       pll_locked,
    output logic       poci_spi,
    output logic       clk_enable,
    output logic [5:0] vco_digital_band,
    output logic [7:0] trigger_channel_mask,
    output logic [1:0] mode,
    output logic [7:0] disc_polarity,
    output logic [4:0] ref_clk_sel,
    output logic       slow_mode,
    output logic [5:0] trigger_delay,
    output logic       pll_switch,
    output logic [2:0] select_reg,
    output logic       inst_rst,
    output logic       inst_readout,
    output logic       inst_start
);

    localparam logic [6:0] ADDR_VCO    = 7'd1;
    localparam logic [6:0] ADDR_MASK   = 7'd2;
    localparam logic [6:0] ADDR_INST   = 7'd3;
    localparam logic [6:0] ADDR_MODE   = 7'd4;
    localparam logic [6:0] ADDR_POL    = 7'd5;
    localparam logic [6:0] ADDR_REFSEL = 7'd6;
    localparam logic [6:0] ADDR_SLOW   = 7'd7;
    localparam logic [6:0] ADDR_DELAY  = 7'd8;
    localparam logic [6:0] ADDR_PLLSW  = 7'd9;
    localparam logic [6:0] ADDR_SEL    = 7'd10;

    localparam logic [7:0] CODE_RST     = 8'd1;
    localparam logic [7:0] CODE_READOUT = 8'd2;
    localparam logic [7:0] CODE_START   = 8'd3;

    logic [3:0]  bit_cnt;
    logic [14:0] shift_in;
    logic [15:0] frame_word;
    logic        hdr_edge;
    logic        commit_edge;
    logic        wr_vld;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_dat;
    logic        rd_load;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_dat;
    logic [7:0]  poci_sr;
    logic        inst_wr;
    logic        rst_cmd;
    logic        readout_cmd;
    logic        start_cmd;
    logic        start_ok;
    logic        gate_clr;

    // frame_word includes the bit being sampled on this edge
    assign frame_word  = {shift_in, pico};
    assign hdr_edge    = cs & (bit_cnt == 4'd7);
    assign commit_edge = cs & (bit_cnt == 4'd15);

    assign wr_vld  = commit_edge & frame_word[15];
    assign wr_addr = frame_word[14:8];
    assign wr_dat  = frame_word[7:0];
    assign rd_load = hdr_edge & ~frame_word[7];
    assign rd_addr = frame_word[6:0];

    assign inst_wr     = wr_vld & (wr_addr == ADDR_INST);
    assign rst_cmd     = inst_wr & (wr_dat == CODE_RST);
    assign readout_cmd = inst_wr & (wr_dat == CODE_READOUT);
    assign start_cmd   = inst_wr & (wr_dat == CODE_START);

`ifdef PSEC6_SPI_PLL_GATE_EN
    assign start_ok = pll_locked;
    assign gate_clr = pll_switch & ~pll_locked;
`else
    logic unused_pll_locked;
    assign unused_pll_locked = pll_locked;
    assign start_ok          = 1'b1;
    assign gate_clr          = 1'b0;
`endif

    always_ff @(posedge spi_clk) begin
        if (rst || !cs) begin
            bit_cnt  <= 4'd0;
            shift_in <= '0;
        end else begin
            bit_cnt  <= bit_cnt + 4'd1;
            shift_in <= {shift_in[13:0], pico};
        end
    end

    always_comb begin
        rd_dat = 8'h00;
        case (rd_addr)
            ADDR_VCO:    rd_dat = {2'b00, vco_digital_band};
            ADDR_MASK:   rd_dat = trigger_channel_mask;
            ADDR_MODE:   rd_dat = {6'b0, mode};
            ADDR_POL:    rd_dat = disc_polarity;
            ADDR_REFSEL: rd_dat = {3'b0, ref_clk_sel};
            ADDR_SLOW:   rd_dat = {7'b0, slow_mode};
            ADDR_DELAY:  rd_dat = {2'b00, trigger_delay};
            ADDR_PLLSW:  rd_dat = {7'b0, pll_switch};
            ADDR_SEL:    rd_dat = {5'b0, select_reg};
            default:     rd_dat = 8'h00;
        endcase
    end

    // Load on the header edge, shift through the data phase, hold bit 0 on the last edge
    always_ff @(posedge spi_clk) begin
        if (rst || !cs) begin
            poci_sr <= '0;
        end else if (bit_cnt == 4'd7) begin
            poci_sr <= rd_load ? rd_dat : 8'h00;
        end else if (bit_cnt == 4'd15) begin
            poci_sr <= poci_sr;
        end else if (bit_cnt > 4'd7) begin
            poci_sr <= {poci_sr[6:0], 1'b0};
        end else begin
            poci_sr <= '0;
        end
    end

    assign poci_spi = poci_sr[7];

    always_ff @(posedge spi_clk) begin
        if (rst) begin
            vco_digital_band     <= '0;
            trigger_channel_mask <= '0;
            mode                 <= '0;
            disc_polarity        <= '0;
            ref_clk_sel          <= '0;
            slow_mode            <= 1'b0;
            trigger_delay        <= '0;
            pll_switch           <= 1'b0;
            select_reg           <= '0;
        end else if (wr_vld) begin
            case (wr_addr)
                ADDR_VCO:    vco_digital_band     <= wr_dat[5:0];
                ADDR_MASK:   trigger_channel_mask <= wr_dat;
                ADDR_MODE:   mode                 <= wr_dat[1:0];
                ADDR_POL:    disc_polarity        <= wr_dat;
                ADDR_REFSEL: ref_clk_sel          <= wr_dat[4:0];
                ADDR_SLOW:   slow_mode            <= wr_dat[0];
                ADDR_DELAY:  trigger_delay        <= wr_dat[5:0];
                ADDR_PLLSW:  pll_switch           <= wr_dat[0];
                ADDR_SEL:    select_reg           <= wr_dat[2:0];
                default:     ;
            endcase
        end
    end

    // Single-cycle strobes; downstream edge-detects them
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            inst_rst     <= 1'b0;
            inst_readout <= 1'b0;
            inst_start   <= 1'b0;
        end else begin
            inst_rst     <= rst_cmd;
            inst_readout <= readout_cmd;
            inst_start   <= start_cmd;
        end
    end

    // trigger_in is the only asynchronous path; every clear source outranks start
    always_ff @(posedge spi_clk or posedge trigger_in) begin
        if (trigger_in) begin
            clk_enable <= 1'b0;
        end else if (rst) begin
            clk_enable <= 1'b0;
        end else if (gate_clr || rst_cmd) begin
            clk_enable <= 1'b0;
        end else if (start_cmd && start_ok) begin
            clk_enable <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psec6_spi_core.sv
// Bench for psec6_spi_core: directed frames followed by randomized frames,
// checked against a register-array model of the SPI register map.
module tb_psec6_spi_core;

    logic       spi_clk;
    logic       rst;
    logic       cs;
    logic       pico;
    logic       trigger_in;
    logic       pll_locked;
    logic       poci_spi;
    logic       clk_enable;
    logic [5:0] vco_digital_band;
    logic [7:0] trigger_channel_mask;
    logic [1:0] mode;
    logic [7:0] disc_polarity;
    logic [4:0] ref_clk_sel;
    logic       slow_mode;
    logic [5:0] trigger_delay;
    logic       pll_switch;
    logic [2:0] select_reg;
    logic       inst_rst;
    logic       inst_readout;
    logic       inst_start;

    psec6_spi_core dut (
        .spi_clk              (spi_clk),
        .rst                  (rst),
        .cs                   (cs),
        .pico                 (pico),
        .trigger_in           (trigger_in),
        .pll_locked           (pll_locked),
        .poci_spi             (poci_spi),
        .clk_enable           (clk_enable),
        .vco_digital_band     (vco_digital_band),
        .trigger_channel_mask (trigger_channel_mask),
        .mode                 (mode),
        .disc_polarity        (disc_polarity),
        .ref_clk_sel          (ref_clk_sel),
        .slow_mode            (slow_mode),
        .trigger_delay        (trigger_delay),
        .pll_switch           (pll_switch),
        .select_reg           (select_reg),
        .inst_rst             (inst_rst),
        .inst_readout         (inst_readout),
        .inst_start           (inst_start)
    );

    initial spi_clk = 1'b0;
    always #20 spi_clk = ~spi_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_reg [0:127];
    logic        m_clk_en;
    logic [39:0] dut_cfg;

    assign dut_cfg = {vco_digital_band, trigger_channel_mask, mode, disc_polarity,
                      ref_clk_sel, slow_mode, trigger_delay, pll_switch, select_reg};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Register width per address; zero means the address holds no readable state
    function automatic logic [7:0] reg_mask(input int a);
        case (a)
            1:       return 8'h3F;
            2:       return 8'hFF;
            4:       return 8'h03;
            5:       return 8'hFF;
            6:       return 8'h1F;
            7:       return 8'h01;
            8:       return 8'h3F;
            9:       return 8'h01;
            10:      return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [39:0] exp_cfg();
        return {m_reg[1][5:0], m_reg[2], m_reg[4][1:0], m_reg[5], m_reg[6][4:0],
                m_reg[7][0], m_reg[8][5:0], m_reg[9][0], m_reg[10][2:0]};
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 128; a++) m_reg[a] = 8'h00;
        m_clk_en = 1'b0;
    endtask

    task automatic do_edge(input logic c, input logic d, input logic r);
        @(negedge spi_clk);
        cs   = c;
        pico = d;
        rst  = r;
        @(posedge spi_clk);
        #1;
        if (r) model_reset();
        if (trigger_in) m_clk_en = 1'b0;
`ifdef PSEC6_SPI_PLL_GATE_EN
        if (m_reg[9][0] && !pll_locked) m_clk_en = 1'b0;
`endif
    endtask

    task automatic send_frame(input logic [15:0] w);
        logic       is_rd;
        logic [7:0] rdv;
        logic [2:0] exp_str;
        logic       psw_old;
        logic       e;
        int         a;
        is_rd   = ~w[15];
        a       = int'(w[14:8]);
        rdv     = m_reg[a];
        exp_str = 3'b000;
        psw_old = m_reg[9][0];
        for (int i = 0; i < 16; i++) begin
            do_edge(1'b1, w[15-i], 1'b0);
            if (i == 15 && !is_rd) begin
                m_reg[a] = w[7:0] & reg_mask(a);
                if (a == 3) begin
                    case (w[7:0])
                        8'd1: begin exp_str = 3'b100; m_clk_en = 1'b0; end
                        8'd2: exp_str = 3'b010;
                        8'd3: begin
                            exp_str = 3'b001;
`ifdef PSEC6_SPI_PLL_GATE_EN
                            if (pll_locked) m_clk_en = 1'b1;
`else
                            m_clk_en = 1'b1;
`endif
                        end
                        default: exp_str = 3'b000;
                    endcase
                end
                if (trigger_in) m_clk_en = 1'b0;
`ifdef PSEC6_SPI_PLL_GATE_EN
                if (psw_old && !pll_locked) m_clk_en = 1'b0;
`endif
            end
            if (!is_rd || i < 7) e = 1'b0;
            else if (i < 15)     e = rdv[14-i];
            else                 e = rdv[0];
            check("poci", 64'(poci_spi), 64'(e));
            check("strobe", 64'({inst_rst, inst_readout, inst_start}),
                  64'((i == 15) ? exp_str : 3'b000));
            if (i == 15) check("clk_en_commit", 64'(clk_enable), 64'(m_clk_en));
        end
        do_edge(1'b0, 1'b0, 1'b0);
        check("poci_idle", 64'(poci_spi), 64'd0);
        check("strobe_idle", 64'({inst_rst, inst_readout, inst_start}), 64'd0);
        check("cfg", 64'(dut_cfg), 64'(exp_cfg()));
        check("clk_en", 64'(clk_enable), 64'(m_clk_en));
    endtask

    task automatic pulse_trigger();
        @(negedge spi_clk);
        trigger_in = 1'b1;
        #25;
        trigger_in = 1'b0;
        m_clk_en   = 1'b0;
        #1;
        check("trig_clr", 64'(clk_enable), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [6:0]  ra;
        logic [7:0]  rdat;
        logic        rrw;
        int          addrs [8];
        addrs = '{2, 4, 5, 6, 7, 8, 9, 10};

        cs = 1'b0; pico = 1'b0; rst = 1'b1; trigger_in = 1'b0; pll_locked = 1'b1;
        model_reset();
        do_edge(1'b0, 1'b0, 1'b1);
        do_edge(1'b0, 1'b0, 1'b1);
        do_edge(1'b0, 1'b0, 1'b0);
        check("rst_cfg", 64'(dut_cfg), 64'd0);
        check("rst_clk_en", 64'(clk_enable), 64'd0);
        check("rst_poci", 64'(poci_spi), 64'd0);
        check("rst_strobe", 64'({inst_rst, inst_readout, inst_start}), 64'd0);

        send_frame(16'h81FF);
        check("vco_3f", 64'(vco_digital_band), 64'h3F);
        send_frame(16'h8303);
        check("start_en", 64'(clk_enable), 64'd1);
        pulse_trigger();
        send_frame(16'h0100);
        send_frame(16'h8301);
        send_frame(16'h8302);

        foreach (addrs[k]) send_frame({1'b1, 7'(addrs[k]), 8'hA5});
        foreach (addrs[k]) send_frame({1'b0, 7'(addrs[k]), 8'h00});
        send_frame(16'h80A5);
        send_frame(16'h8CA5);
        send_frame(16'h0000);
        send_frame(16'h0C00);
        send_frame(16'h0300);

        // Start committed while trigger is held high
        trigger_in = 1'b1;
        send_frame(16'h8303);
        trigger_in = 1'b0;
        check("start_under_trig", 64'(clk_enable), 64'd0);

        // Reset coinciding with a start commit
        send_frame(16'h8303);
        w = 16'h8303;
        for (int i = 0; i < 15; i++) do_edge(1'b1, w[15-i], 1'b0);
        do_edge(1'b1, w[0], 1'b1);
        check("rst_commit_strobe", 64'(inst_start), 64'd0);
        check("rst_commit_clk_en", 64'(clk_enable), 64'(m_clk_en));
        check("rst_commit_cfg", 64'(dut_cfg), 64'd0);
        do_edge(1'b0, 1'b0, 1'b0);

        // Reset mid-frame aborts, next frame decodes cleanly
        send_frame(16'h81FF);
        w = 16'h8203;
        for (int i = 0; i < 7; i++) do_edge(1'b1, w[15-i], 1'b0);
        do_edge(1'b1, 1'b0, 1'b1);
        check("rst_mid_cfg", 64'(dut_cfg), 64'd0);
        do_edge(1'b0, 1'b0, 1'b0);
        send_frame(16'h8212);
        send_frame(16'h0200);

        for (int n = 0; n < 90; n++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ra = 7'($urandom_range(0, 127));
            else                           ra = 7'($urandom_range(0, 12));
            if (ra == 7'd3) rdat = 8'($urandom_range(0, 4));
            else            rdat = 8'($urandom_range(0, 255));
            rrw = 1'($urandom_range(0, 1));
            send_frame({rrw, ra, rdat});
            if ($urandom_range(0, 5) == 0) pulse_trigger();
        end

        // Start with the PLL unlocked
        pulse_trigger();
        pll_locked = 1'b0;
        send_frame(16'h8303);
`ifdef PSEC6_SPI_PLL_GATE_EN
        check("gate_start", 64'(clk_enable), 64'd0);
`else
        check("nogate_start", 64'(clk_enable), 64'd1);
`endif
        pll_locked = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
